truth_table_sweeper: RTL and testbench
======================================

// Module: truth_table_sweeper
// PURPOSE
//   Parametrised hardware sweeper for an N-input, 1-output combinational block.
//   On start it drives every input vector 0..2^N_IN-1 in ascending order, waits a
//   settle window and samples the block's output. It compares each sample against
//   an expected truth table and reports a pass flag, an error count and the first
//   failing index. Sits beside a combinational exercise block as a self-checking harness.
// PARAMETERS
//   N_IN      3          number of DUT inputs (1..8); table depth = 2**N_IN
//   SETTLE    1          extra hold cycles per vector before sampling (0..255)
//   EXPECTED  8'hE8      expected truth table, width 2**N_IN; bit i = expected out for vec==i
// PORTS
//   clk            in   1           single clock, rising edge
//   rst_n          in   1           asynchronous active-low reset
//   start          in   1           begin sweep; sampled only in IDLE
//   vec            out  N_IN        input vector driven to the DUT
//   dut_out        in   1           DUT output for the current vec
//   busy           out  1           high from the cycle after start until done
//   done           out  1           one-cycle pulse at sweep end
//   pass           out  1           err_cnt==0; valid from done, held until next start
//   err_cnt        out  N_IN+1      number of mismatching vectors (0..2**N_IN)
//   first_err_vld  out  1           at least one mismatch seen
//   first_err_idx  out  N_IN        index of the lowest mismatching vector
//   tt_obs         out  2**N_IN     observed truth table (see CONFIGURATION)
// BEHAVIOUR
//   - Reset (async, rst_n=0): state=IDLE; vec=0, busy=0, done=0, pass=0, err_cnt=0,
//     first_err_vld=0, first_err_idx=0, tt_obs=0, settle counter=0.
//   - FSM states: IDLE -> HOLD -> (SAMPLE edge) -> HOLD ... -> DONE -> IDLE.
//     IDLE: start=1 at edge E0 -> vec=0, settle cnt=SETTLE, err_cnt/first_err/pass/tt_obs
//       cleared, busy=1, go HOLD.
//     HOLD: cnt!=0 -> decrement. cnt==0 -> that edge is the sample edge: compare
//       dut_out with EXPECTED[vec]; mismatch -> err_cnt+1; if first_err_vld=0, latch
//       first_err_idx=vec and set first_err_vld. If vec==2**N_IN-1 -> go DONE, else
//       vec+1, cnt=SETTLE.
//     DONE: done=1, busy=0, pass=(err_cnt==0) for one cycle, then IDLE. vec holds last value.
//   - Each vector is held SETTLE+1 cycles. Sample edges are E0+k*(SETTLE+1), k=1..2**N_IN;
//     done is high in the cycle following the last sample edge.
//   - SETTLE=0: one vector per cycle, sampled on the edge after it is driven.
//   - err_cnt is N_IN+1 bits; all-fail (2**N_IN) fits, no saturation or wrap needed.
//   - vec increments only inside a sweep and never wraps; the sweep ends at 2**N_IN-1.
//   - start while busy or in DONE is ignored (no restart, no queueing).
//   - Results (pass, err_cnt, first_err_*, tt_obs) hold in IDLE until the next accepted start.
//   - rst_n asserted mid-sweep aborts immediately to reset values; no partial result kept.
// CONFIGURATION
//   TT_CAPTURE_EN defined: tt_obs[vec] <= dut_out at every sample edge, so the full
//     observed table is readable after done.
//   TT_CAPTURE_EN undefined: no capture register; tt_obs is tied to 0. Other behaviour unchanged.
// TESTING
//   T1 N_IN=3,SETTLE=1,EXPECTED=8'hE8, DUT=majority -> done 16 cycles after start,
//      pass=1, err_cnt=0, first_err_vld=0.
//   T2 same params, DUT=~majority -> err_cnt=8, pass=0, first_err_idx=0.
//   T3 DUT=majority but output flipped only at vec=5 -> err_cnt=1, first_err_idx=5,
//      first_err_vld=1.
//   T4 start pulsed again at cycle 4 of a sweep -> ignored; single done at cycle 16,
//      vec sequence 0..7 with each value held 2 cycles.
//   T5 rst_n low at cycle 7 mid-sweep -> all outputs 0 asynchronously; new start gives
//      a full clean sweep with a correct result.
//   T6 N_IN=4,SETTLE=0,TT_CAPTURE_EN defined, DUT=XOR of inputs -> done after 16 cycles;
//      tt_obs=16'h6996; pass=1 iff EXPECTED=16'h6996.

Source files
------------

// File: rtl/truth_table_sweeper.sv
// truth_table_sweeper: drives every N_IN-bit vector in ascending order, samples dut_out after SETTLE extra cycles and checks it against EXPECTED.
// Define TT_CAPTURE_EN to record the observed truth table on tt_obs; otherwise tt_obs is tied to 0.
module truth_table_sweeper #(
  parameter int N_IN = 3,
  parameter int SETTLE = 1,
  parameter logic [2**N_IN-1:0] EXPECTED = 8'hE8
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 start,
  output logic [N_IN-1:0]      vec,
  input  logic                 dut_out,
  output logic                 busy,
  output logic                 done,
  output logic                 pass,
  output logic [N_IN:0]        err_cnt,
  output logic                 first_err_vld,
  output logic [N_IN-1:0]      first_err_idx,
  output logic [2**N_IN-1:0]   tt_obs
);
  localparam logic [N_IN-1:0] LAST = '1;
  typedef enum logic [1:0] {IDLE, HOLD, DONE} state_t;
  state_t state_q, state_d;
  logic [N_IN-1:0] vec_q, vec_d, fidx_q, fidx_d;
  logic [7:0] cnt_q, cnt_d;
  logic [N_IN:0] err_q, err_d;
  logic fvld_q, fvld_d, pass_q, pass_d, mis;
`ifdef TT_CAPTURE_EN
  logic [2**N_IN-1:0] tt_q, tt_d;
`endif
  assign mis = dut_out ^ EXPECTED[vec_q];
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      vec_q   <= '0;
      cnt_q   <= '0;
      err_q   <= '0;
      fvld_q  <= 1'b0;
      fidx_q  <= '0;
      pass_q  <= 1'b0;
`ifdef TT_CAPTURE_EN
      tt_q    <= '0;
`endif
    end else begin
      state_q <= state_d;
      vec_q   <= vec_d;
      cnt_q   <= cnt_d;
      err_q   <= err_d;
      fvld_q  <= fvld_d;
      fidx_q  <= fidx_d;
      pass_q  <= pass_d;
`ifdef TT_CAPTURE_EN
      tt_q    <= tt_d;
`endif
    end
  end
  always_comb begin
    state_d = state_q;
    vec_d   = vec_q;
    cnt_d   = cnt_q;
    err_d   = err_q;
    fvld_d  = fvld_q;
    fidx_d  = fidx_q;
    pass_d  = pass_q;
`ifdef TT_CAPTURE_EN
    tt_d    = tt_q;
`endif
    case (state_q)
      IDLE: if (start) begin
        state_d = HOLD;
        vec_d   = '0;
        cnt_d   = 8'(SETTLE);
        err_d   = '0;
        fvld_d  = 1'b0;
        fidx_d  = '0;
        pass_d  = 1'b0;
`ifdef TT_CAPTURE_EN
        tt_d    = '0;
`endif
      end
      HOLD: if (cnt_q != '0) begin
        cnt_d = cnt_q - 8'd1;
      end else begin
        // cnt reached zero: this edge samples dut_out for vec_q
        err_d = err_q + (N_IN+1)'(mis);
        if (mis && !fvld_q) begin
          fvld_d = 1'b1;
          fidx_d = vec_q;
        end
`ifdef TT_CAPTURE_EN
        tt_d[vec_q] = dut_out;
`endif
        if (vec_q == LAST) begin
          state_d = DONE;
          pass_d  = (err_d == '0);
        end else begin
          vec_d = vec_q + 1'b1;
          cnt_d = 8'(SETTLE);
        end
      end
      default: state_d = IDLE;
    endcase
  end
  assign vec           = vec_q;
  assign busy          = (state_q == HOLD);
  assign done          = (state_q == DONE);
  assign pass          = pass_q;
  assign err_cnt       = err_q;
  assign first_err_vld = fvld_q;
  assign first_err_idx = fidx_q;
`ifdef TT_CAPTURE_EN
  assign tt_obs = tt_q;
`else
  assign tt_obs = '0;
`endif
endmodule

// File: tb/tb_truth_table_sweeper.sv
// tb_truth_table_sweeper: checks two sweeper instances (3-in majority, settle 1; 4-in xor, settle 0) against a cycle-count model.
module tb_truth_table_sweeper;
  typedef struct packed {
    logic busy, done, pass, fvld;
    logic [7:0] vec, err, fidx;
  } exp_t;
  logic clk = 1'b0, rst_n = 1'b0, start = 1'b0;
  int mode = 0, m_q = 0, n = -1;
  int checks = 0, errors = 0;
  logic [2:0] vec_a, fidx_a;
  logic [3:0] vec_b, fidx_b, err_a;
  logic [4:0] err_b;
  logic [7:0] tt_obs_a;
  logic [15:0] tt_obs_b;
  logic dut_out_a, dut_out_b, busy_a, busy_b, done_a, done_b, pass_a, pass_b, fvld_a, fvld_b;
  always #5 clk = ~clk;
  truth_table_sweeper #(.N_IN(3), .SETTLE(1), .EXPECTED(8'hE8)) dut_a (
    .clk(clk), .rst_n(rst_n), .start(start), .vec(vec_a), .dut_out(dut_out_a),
    .busy(busy_a), .done(done_a), .pass(pass_a), .err_cnt(err_a),
    .first_err_vld(fvld_a), .first_err_idx(fidx_a), .tt_obs(tt_obs_a));
  truth_table_sweeper #(.N_IN(4), .SETTLE(0), .EXPECTED(16'h6996)) dut_b (
    .clk(clk), .rst_n(rst_n), .start(start), .vec(vec_b), .dut_out(dut_out_b),
    .busy(busy_b), .done(done_b), .pass(pass_b), .err_cnt(err_b),
    .first_err_vld(fvld_b), .first_err_idx(fidx_b), .tt_obs(tt_obs_b));
  function automatic logic f_a(int m, logic [2:0] v);
    logic maj = (v[0] & v[1]) | (v[0] & v[2]) | (v[1] & v[2]);
    return m == 1 ? !maj : m == 2 ? maj ^ (v == 3'd5) : maj;
  endfunction
  assign dut_out_a = f_a(mode, vec_a);
  assign dut_out_b = ^vec_b;
  function automatic logic [15:0] mis_a(int m);
    logic [7:0] e = 8'hE8;
    logic [15:0] r = '0;
    for (int i = 0; i < 8; i++) r[i] = f_a(m, 3'(i)) ^ e[i];
    return r;
  endfunction
  function automatic logic [15:0] mis_b();
    logic [15:0] e = 16'h6996;
    logic [15:0] r = '0;
    for (int i = 0; i < 16; i++) r[i] = (^4'(i)) ^ e[i];
    return r;
  endfunction
  // n counts clock edges since the accepted start edge; -1 means reset values
  function automatic exp_t model(int nb, int s, logic [15:0] mis, int cyc);
    int d = 1 << nb;
    int s1 = s + 1;
    int t = d * s1;
    int k;
    exp_t e = '0;
    if (cyc < 0) return e;
    k = (cyc / s1 < d) ? cyc / s1 : d;
    e.busy = cyc < t;
    e.done = cyc == t;
    e.vec = 8'(cyc < t ? cyc / s1 : d - 1);
    for (int i = 0; i < k; i++)
      if (mis[i]) begin
        if (!e.fvld) e.fidx = 8'(i);
        e.fvld = 1'b1;
        e.err = e.err + 8'd1;
      end
    e.pass = cyc >= t && e.err == 0;
    return e;
  endfunction
  task automatic chk(string nm, logic [63:0] act, logic [63:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s at %0t: got %0h expected %0h", nm, $time, act, req);
    end
  endtask
  always @(posedge clk or negedge rst_n)
    if (!rst_n) n <= -1;
    else if ((n < 0 || n > 16) && start) begin
      n <= 0;
      m_q <= mode;
    end else if (n >= 0) n <= n + 1;
  always @(negedge clk) begin
    exp_t act;
    act = {busy_a, done_a, pass_a, fvld_a, 8'(vec_a), 8'(err_a), 8'(fidx_a)};
    chk("cyc_a", 64'(act), 64'(model(3, 1, mis_a(m_q), n)));
    act = {busy_b, done_b, pass_b, fvld_b, 8'(vec_b), 8'(err_b), 8'(fidx_b)};
    chk("cyc_b", 64'(act), 64'(model(4, 0, mis_b(), n)));
`ifndef TT_CAPTURE_EN
    chk("tt_a_zero", 64'(tt_obs_a), 64'd0);
`endif
  end
  task automatic run_sweep(int m, int g, output int lat);
    mode = m;
    @(negedge clk);
    start = 1'b1;
    @(posedge clk);
    #1 start = 1'b0;
    lat = 0;
    while (!done_a && lat < 40) begin
      @(posedge clk);
      #1 lat++;
      start = (lat == g);
    end
    start = 1'b0;
    if (!done_a) chk("done_timeout", 64'(lat), 64'd16);
  endtask
  initial begin
    int lat, cnt;
    repeat (2) @(negedge clk);
    chk("rst_busy", 64'(busy_a), 64'd0);
    chk("rst_vec", 64'(vec_a), 64'd0);
    rst_n = 1'b1;
    // T1 / T6: majority on A, xor on B
    run_sweep(0, -1, lat);
    chk("t1_lat", 64'(lat), 64'd16);
    chk("t1_err", 64'(err_a), 64'd0);
    chk("t1_pass", 64'(pass_a), 64'd1);
    chk("t1_fvld", 64'(fvld_a), 64'd0);
    chk("t6_done", 64'(done_b), 64'd1);
    chk("t6_pass", 64'(pass_b), 64'd1);
`ifdef TT_CAPTURE_EN
    chk("t6_tt", 64'(tt_obs_b), 64'h6996);
    chk("t1_tt", 64'(tt_obs_a), 64'hE8);
`else
    chk("t6_tt", 64'(tt_obs_b), 64'h0);
`endif
    repeat (3) @(posedge clk);
    #1 chk("t1_hold_pass", 64'(pass_a), 64'd1);
    // T2: inverted majority
    run_sweep(1, -1, lat);
    chk("t2_err", 64'(err_a), 64'd8);
    chk("t2_pass", 64'(pass_a), 64'd0);
    chk("t2_fidx", 64'(fidx_a), 64'd0);
    repeat (2) @(posedge clk);
    // T3: single flipped entry at vec 5
    run_sweep(2, -1, lat);
    chk("t3_err", 64'(err_a), 64'd1);
    chk("t3_fidx", 64'(fidx_a), 64'd5);
    chk("t3_fvld", 64'(fvld_a), 64'd1);
    repeat (2) @(posedge clk);
    // T4: start mid-sweep is ignored
    run_sweep(0, 4, lat);
    chk("t4_lat", 64'(lat), 64'd16);
    cnt = 0;
    repeat (20) begin
      @(posedge clk);
      #1 cnt += int'(done_a);
    end
    chk("t4_extra_done", 64'(cnt), 64'd0);
    // T5: async reset mid-sweep, then clean sweep
    mode = 1;
    @(negedge clk);
    start = 1'b1;
    @(posedge clk);
    #1 start = 1'b0;
    repeat (7) @(posedge clk);
    #2 rst_n = 1'b0;
    #1 chk("t5_async", 64'({busy_a, done_a, pass_a, fvld_a, vec_a, err_a, fidx_a}), 64'd0);
    chk("t5_async_b", 64'({busy_b, vec_b, err_b}), 64'd0);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    run_sweep(0, -1, lat);
    chk("t5_lat", 64'(lat), 64'd16);
    chk("t5_pass", 64'(pass_a), 64'd1);
    repeat (2) @(posedge clk);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
